// File: rtl/sounder_pkg.sv
// sounder_pkg
// Shared types and widths for the sounder receive capture scheduler.
// Contents:
//   state_t  - capture FSM encoding (S_IDLE..S_DONE, 3-bit)
//   TS_W     - timestamp width
//   CNT_W    - burst length / period counter width
//   NBURST_W - burst count width
package sounder_pkg;

  localparam int TS_W     = 64;
  localparam int CNT_W    = 32;
  localparam int NBURST_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_PASS = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sounder_rx_sched_cnt.sv
// sounder_rx_sched_cnt
// Compare-and-wrap counter. Counts from 1 up to limit; an enabled step
// taken while count == limit wraps back to 1. Used for beat, gap and
// burst counting in the capture scheduler.
// Ports:
//   clk, rst_n - clock, async active-low reset (count resets to 1)
//   clr        - synchronous return to 1 (priority over en)
//   en         - advance by one step
//   limit      - terminal count
//   count      - current value
//   hit        - count == limit
module sounder_rx_sched_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit
);

  assign hit = (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(1);
    end else if (clr) begin
      count <= W'(1);
    end else if (en) begin
      count <= hit ? W'(1) : count + W'(1);
    end
  end

endmodule

// File: rtl/sounder_rx_sched.sv
// sounder_rx_sched
// Timed capture scheduler in front of the sounder receive averager.
// Accepts one capture command (start time, burst count, burst length,
// burst period), forwards only the beats inside the scheduled bursts,
// frames each burst with o_tlast and reports busy/done/late to the host.
// The datapath is combinational: no buffering, zero latency.
//
// Optional build macro:
//   SOUNDER_RX_SCHED_DROPCNT_EN - adds drop_cnt, a saturating count of
//                                 beats discarded while busy.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   cmd_valid/cmd_ready   - command handshake (ready only when idle)
//   cmd_time, cmd_now     - start timestamp / start on next valid beat
//   cmd_nburst, cmd_blen,
//   cmd_period            - bursts, beats per burst, beats between starts
//   abort                 - terminate capture
//   i_*                   - radio sample stream in (i_time = beat timestamp)
//   o_*                   - gated sample stream out, o_tlast ends a burst
//   busy, done, late      - capture status (done is a one-cycle pulse,
//                           late is sticky until the next command)
//   drop_cnt              - (optional) dropped beat count
module sounder_rx_sched
  import sounder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NIPC   = 2,
  parameter int TS_INC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [TS_W-1:0]       cmd_time,
  input  logic                  cmd_now,
  input  logic [NBURST_W-1:0]   cmd_nburst,
  input  logic [CNT_W-1:0]      cmd_blen,
  input  logic [CNT_W-1:0]      cmd_period,
  input  logic                  abort,
  input  logic [NIPC*WIDTH-1:0] i_tdata,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  input  logic [TS_W-1:0]       i_time,
  output logic [NIPC*WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic                  o_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  late
`ifdef SOUNDER_RX_SCHED_DROPCNT_EN
  ,
  output logic [31:0]           drop_cnt
`endif
);

  state_t                state;
  logic [TS_W-1:0]       time_r;
  logic                  now_r;
  logic [NBURST_W-1:0]   nburst_r;
  logic [CNT_W-1:0]      blen_r;
  logic [CNT_W-1:0]      period_r;

  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]      gap_cnt;
  logic [CNT_W-1:0]      gap_len;
  logic [NBURST_W-1:0]   burst_cnt;
  logic                  beat_hit;
  logic                  gap_hit;
  logic                  burst_hit;

  logic                  cmd_acc;
  logic                  pass;
  logic                  hs;
  logic                  pass_hs;
  logic                  gap_step;
  logic                  has_gap;
  logic                  burst_step;

  // The timestamp step is fixed by the radio front end; the scheduler
  // compares absolute timestamps, so the step only documents the stream.
  logic [31:0]           unused_ts_inc;
  assign unused_ts_inc = 32'(TS_INC);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign cmd_acc   = cmd_valid & cmd_ready;

  // A waiting capture opens on the first valid beat at or after the start
  // time, so that beat is forwarded in the same cycle it is qualified.
  assign pass = (state == S_PASS) |
                ((state == S_WAIT) & i_tvalid & (now_r | (i_time >= time_r)));

  // Outside a burst the radio is always accepted and the beat discarded.
  assign i_tready = pass ? o_tready : 1'b1;
  assign o_tvalid = pass & i_tvalid;
  assign o_tdata  = i_tdata;
  assign o_tlast  = pass & i_tvalid & (beat_hit | abort);

  assign hs       = i_tvalid & i_tready;
  assign pass_hs  = pass & hs;
  assign gap_step = (state == S_GAP) & hs;
  assign has_gap  = (period_r > blen_r);
  assign gap_len  = has_gap ? (period_r - blen_r) : '0;

  // A new burst begins either back-to-back at the end of the previous one
  // or after the last gap beat has been dropped.
  assign burst_step = (pass_hs & beat_hit & ~burst_hit & ~has_gap) |
                      (gap_step & gap_hit);

  // beat_cnt always holds the number of the beat currently on the input,
  // so the end-of-burst test is the same in S_WAIT and S_PASS.
  sounder_rx_sched_cnt #(.W(CNT_W)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_acc),
    .en    (pass_hs),
    .limit (blen_r),
    .count (beat_cnt),
    .hit   (beat_hit)
  );

  sounder_rx_sched_cnt #(.W(CNT_W)) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_acc),
    .en    (gap_step),
    .limit (gap_len),
    .count (gap_cnt),
    .hit   (gap_hit)
  );

  sounder_rx_sched_cnt #(.W(NBURST_W)) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_acc),
    .en    (burst_step),
    .limit (nburst_r),
    .count (burst_cnt),
    .hit   (burst_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      time_r   <= '0;
      now_r    <= 1'b0;
      nburst_r <= '0;
      blen_r   <= '0;
      period_r <= '0;
      done     <= 1'b0;
      late     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            time_r   <= cmd_time;
            now_r    <= cmd_now;
            nburst_r <= cmd_nburst;
            blen_r   <= cmd_blen;
            period_r <= cmd_period;
            late     <= 1'b0;
            if ((cmd_nburst == '0) || (cmd_blen == '0)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (pass_hs && !now_r && (i_time > time_r)) begin
            late <= 1'b1;
          end
          if (abort) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (pass_hs) begin
            if (beat_hit && burst_hit) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (beat_hit && has_gap) begin
              state <= S_GAP;
            end else begin
              state <= S_PASS;
            end
          end
        end

        S_PASS: begin
          if (abort) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (pass_hs && beat_hit) begin
            if (burst_hit) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (has_gap) begin
              state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (abort) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (gap_step && gap_hit) begin
            state <= S_PASS;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SOUNDER_RX_SCHED_DROPCNT_EN
  // Beats discarded while a capture is active, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (cmd_acc) begin
      drop_cnt <= '0;
    end else if (busy && i_tvalid && !pass && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sounder_rx_sched.md
Name: sounder_rx_sched

Overview:
Timed capture scheduler in front of the sounder receive averager. It accepts one capture command (start time, burst count, burst length, burst period) and gates the radio sample stream. Beats outside the scheduled bursts are discarded, and each burst is framed with tlast. Host status (busy/done/late) is reported back to the register interface.

Parameters:
WIDTH, 32, bits per sample
NIPC, 2, samples per beat
TS_INC, 2, timestamp increment per beat (equals NIPC)

Ports:
clk  in  1  block clock
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command strobe
cmd_ready  out  1  high only in S_IDLE
cmd_time  in  64  start timestamp
cmd_now  in  1  1 = ignore cmd_time, start on next valid beat
cmd_nburst  in  16  bursts per capture
cmd_blen  in  32  beats per burst
cmd_period  in  32  beats from burst start to next burst start
abort  in  1  terminate capture
i_tdata  in  NIPC*WIDTH  radio samples
i_tvalid  in  1  input valid
i_tready  out  1  input ready
i_time  in  64  timestamp of current input beat
o_tdata  out  NIPC*WIDTH  gated samples (= i_tdata)
o_tvalid  out  1  output valid
o_tready  in  1  output ready
o_tlast  out  1  last beat of burst
busy  out  1  capture in progress
done  out  1  one-cycle pulse, capture finished
late  out  1  sticky: start time already passed

Behaviour:
- Reset (async assert, sync deassert):
  - state S_IDLE; counters = 1; done = 0; late = 0; busy = 0.
  - o_tvalid = 0; cmd_ready = 1.
- States: S_IDLE, S_WAIT, S_PASS, S_GAP, S_DONE.
- Command accept:
  - cmd_valid & cmd_ready latches all cmd_* fields and clears late.
  - If nburst == 0 or blen == 0, go to S_DONE; otherwise go to S_WAIT.
- pass = (state == S_PASS) | (state == S_WAIT & i_tvalid & (cmd_now_r | i_time >= time_r)).
- Datapath (combinational, zero latency):
  - When pass: o_tvalid = i_tvalid and i_tready = o_tready.
  - Otherwise: o_tvalid = 0 and i_tready = 1, so beats are dropped and the radio is never stalled.
- All counting happens only on a beat handshake (i_tvalid & i_tready).
- S_WAIT:
  - On a qualifying beat, that beat is burst beat 1 (forwarded).
  - late is set if !cmd_now_r and i_time > time_r.
  - If blen == 1, apply end-of-burst handling; otherwise go to S_PASS with beat_cnt = 2.
- End of burst (beat_cnt == blen):
  - o_tlast = 1.
  - If burst_cnt == nburst, go to S_DONE.
  - Else if period > blen, go to S_GAP with gap_cnt = 1.
  - Else (back-to-back) stay in S_PASS with beat_cnt = 1 and burst_cnt + 1.
- S_GAP:
  - Drops beats.
  - When gap_cnt == period − blen, the next handshaken beat starts the burst in S_PASS; burst_cnt increments.
- S_DONE: pulse done for one cycle, then go to S_IDLE.
- busy = (state != S_IDLE).
- abort (any non-idle state):
  - In S_PASS, a beat handshaken in the same cycle is forwarded with o_tlast forced to 1.
  - Go to S_DONE; done pulses.
- Backpressure in S_PASS stalls the radio; there is no internal buffer.
- Widths: 32-bit comparisons are unsigned; period − blen is computed 32-bit only when period > blen.
- cmd_* inputs are ignored while busy.

Optional Feature:
SOUNDER_RX_SCHED_DROPCNT_EN
- With it: adds output drop_cnt[31:0], counting beats discarded while busy.
  - Saturates at 0xFFFFFFFF.
  - Cleared on command accept and on reset.
- Without it: no port and no counter logic.

Decomposition:
- Package sounder_pkg holds:
  - state encodings S_IDLE..S_DONE (3-bit);
  - TS_W = 64, CNT_W = 32, NBURST_W = 16.
- Natural sub-module: sounder_rx_sched_cnt, a reusable compare-and-wrap counter (enable, limit, hit, wrap-to-1). Instantiated for beat, gap and burst counting.

Test Plan:
1. cmd_time = 1000, nburst = 2, blen = 4, period = 10, i_time stepping +2 from 990, o_tready = 1.
   → Beats at t = 1000..1006 forwarded, tlast at 1006; t = 1008..1018 dropped; t = 1020..1026 forwarded, tlast at 1026; done one cycle after.
2. cmd_time = 500 with first valid beat at i_time = 600.
   → Beat 600 forwarded as beat 1; late = 1 and stays 1 until next command.
3. blen = 3, period = 3, nburst = 3.
   → 9 consecutive beats forwarded; tlast on beats 3, 6, 9; no dropped beat.
4. During S_PASS, o_tready = 0 for 5 cycles.
   → i_tready = 0 for those cycles, beat_cnt holds, no data lost or duplicated.
5. abort during beat 2 of blen = 8 with a handshake in the same cycle.
   → That beat has tlast = 1, done pulses, busy falls.
6. rst_n asserted mid-burst.
   → o_tvalid = 0 immediately (async); after release, cmd_ready = 1 and done/late = 0. With the macro on: nburst = 0 command → done within 2 cycles and drop_cnt = 0.
